morse_keyer: RTL and testbench
==============================

# morse_keyer

Parametrised Morse keyer that accepts ASCII characters over a valid/ready handshake and emits the keyed Morse signal, a unit-rate tick and a gated audio square wave. It generalises the fixed-rate Morse generator: unit rate, tone frequency and clock frequency are parameters, and characters arrive at run time instead of from a fixed message. The block sits between a character source (UART, message sequencer) and the buzzer/LED pins.

## Interface
- CLK_HZ, 50_000_000, input clock frequency
- UNIT_HZ, 4, Morse unit (dot) rate; TICK_DIV = CLK_HZ/UNIT_HZ clocks per unit, ≥ 2
- TONE_HZ, 800, audio tone; TONE_HALF = CLK_HZ/(2*TONE_HZ) clocks per half period, ≥ 1
- iCLK  in  1  system clock
- iRST  in  1  asynchronous, active-high reset
- iCHAR  in  8  ASCII character
- iVALID  in  1  iCHAR valid
- oREADY  out  1  block can accept a character
- oKEY  out  1  Morse key level (1 = mark)
- oSOUND  out  1  tone square wave, gated by oKEY
- oTICK  out  1  one-cycle pulse at each unit boundary
- oERR  out  1  one-cycle pulse: unsupported character accepted
- oBUSY  out  1  character in progress (state ≠ IDLE)

## Operation
- Supported: 'A'–'Z', 'a'–'z' (folded to upper), '0'–'9', ' ' (word gap). Others are unsupported.
- Encoding: len (3 bits, 1..5) and pat (5 bits, element i = pat[len-1-i], 1 = dash, first element sent first).
- States: IDLE, LOAD, MARK, GAP, CGAP, WGAP.
- IDLE: oREADY=1. iVALID&oREADY latches iCHAR, next state LOAD.
- LOAD (1 cycle): decode. Letter/digit → MARK with element index 0. Space → WGAP. Unsupported → oERR=1 for this cycle, → IDLE.
- MARK: oKEY=1 for 1 unit (dot) or 3 units (dash). Then GAP if more elements, else CGAP.
- GAP: oKEY=0 for 1 unit, index+1, → MARK.
- CGAP: oKEY=0 for 3 units, → IDLE.
- WGAP: oKEY=0 for 4 units (with the preceding CGAP gives the standard 7), → IDLE.
- Unit counter restarts at 0 on entry to MARK/GAP/CGAP/WGAP; a unit is exactly TICK_DIV clocks. oTICK pulses when the counter wraps (last cycle of each unit); no pulses in IDLE/LOAD.
- Tone counter runs only while oKEY=1, toggles oSOUND every TONE_HALF clocks; first toggle to 1 on the first cycle of MARK; forced 0 and counter cleared whenever oKEY=0.
- iVALID while oREADY=0 is ignored (not latched); the source holds iCHAR/iVALID until accepted.

## Timing
- Reset (async assert, sync release): state IDLE, oREADY=1, oKEY=0, oSOUND=0, oTICK=0, oERR=0, oBUSY=0, all counters 0.
- Accept at edge N → LOAD during cycle N+1 → oKEY=1 from edge N+2.
- Dot mark = TICK_DIV cycles, dash = 3·TICK_DIV; all outputs registered.
- After CGAP/WGAP/unsupported, oREADY=1 in the cycle following the last gap cycle; back-to-back characters with iVALID held start the next MARK 2 cycles after oREADY rises.
- Total character length = Σ(element units) + (len-1) gaps + 3 units.
- Reset mid-character aborts immediately: oKEY and oSOUND drop asynchronously, pending character lost.

## Structure
- Package morse_pkg: state enum, TICK_DIV/TONE_HALF derivation, function ascii_to_morse(char) → {valid, len, pat}.
- Sub-module morse_rom: combinational ASCII→{valid,len,pat} lookup, registered in LOAD. Rest (FSM, unit counter, tone divider) in morse_keyer.

## Test plan
Parameters for bench: CLK_HZ=100, UNIT_HZ=10 (TICK_DIV=10), TONE_HZ=25 (TONE_HALF=2).
- Reset held 5 cycles → oREADY=1, all other outputs 0; no oTICK while idle 50 cycles.
- 'E' → oKEY high exactly 10 cycles starting 2 cycles after accept, then 30 low, oREADY=1; oSOUND toggles every 2 cycles only while oKEY=1; 4 oTICK pulses.
- 'A' then 'T' with iVALID held → key pattern 10 on/10 off/30 on/30 off, then 'T' 30 on/30 off; second accept exactly when oREADY returns.
- 'e' then ' ' then '5' → 'e' identical to 'E'; space gives oKEY low 30+40 cycles before '5' (five 10-cycle marks).
- '#' → oERR single pulse in LOAD cycle, no oKEY activity, oREADY back after 2 cycles.
- Reset asserted mid-dash of '0' → oKEY/oSOUND 0 same cycle, IDLE after release, next 'E' normal.

Source files
------------

// File: rtl/morse_pkg.sv
// Shared types and helpers for the Morse keyer: FSM states, the per-character
// code word and the ASCII lookup table.
package morse_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    MARK,
    GAP,
    CGAP,
    WGAP
  } state_t;

  // len = 0 with valid = 1 marks the word-gap (space) character
  typedef struct packed {
    logic       valid;
    logic [2:0] len;
    logic [4:0] pat;
  } morse_code_t;

  function automatic int unsigned calc_tick_div(input int unsigned clk_hz,
                                                input int unsigned unit_hz);
    return clk_hz / unit_hz;
  endfunction

  function automatic int unsigned calc_tone_half(input int unsigned clk_hz,
                                                 input int unsigned tone_hz);
    return clk_hz / (2 * tone_hz);
  endfunction

  // pat element i is pat[len-1-i]; 1 = dash
  function automatic morse_code_t ascii_to_morse(input logic [7:0] ch);
    logic [7:0]  c;
    morse_code_t m;
    c = ch;
    if (c >= "a" && c <= "z") c = c - 8'h20;
    m = '{valid: 1'b1, len: 3'd0, pat: 5'b00000};
    case (c)
      "A": m = '{1'b1, 3'd2, 5'b00001};
      "B": m = '{1'b1, 3'd4, 5'b01000};
      "C": m = '{1'b1, 3'd4, 5'b01010};
      "D": m = '{1'b1, 3'd3, 5'b00100};
      "E": m = '{1'b1, 3'd1, 5'b00000};
      "F": m = '{1'b1, 3'd4, 5'b00010};
      "G": m = '{1'b1, 3'd3, 5'b00110};
      "H": m = '{1'b1, 3'd4, 5'b00000};
      "I": m = '{1'b1, 3'd2, 5'b00000};
      "J": m = '{1'b1, 3'd4, 5'b00111};
      "K": m = '{1'b1, 3'd3, 5'b00101};
      "L": m = '{1'b1, 3'd4, 5'b00100};
      "M": m = '{1'b1, 3'd2, 5'b00011};
      "N": m = '{1'b1, 3'd2, 5'b00010};
      "O": m = '{1'b1, 3'd3, 5'b00111};
      "P": m = '{1'b1, 3'd4, 5'b00110};
      "Q": m = '{1'b1, 3'd4, 5'b01101};
      "R": m = '{1'b1, 3'd3, 5'b00010};
      "S": m = '{1'b1, 3'd3, 5'b00000};
      "T": m = '{1'b1, 3'd1, 5'b00001};
      "U": m = '{1'b1, 3'd3, 5'b00001};
      "V": m = '{1'b1, 3'd4, 5'b00001};
      "W": m = '{1'b1, 3'd3, 5'b00011};
      "X": m = '{1'b1, 3'd4, 5'b01001};
      "Y": m = '{1'b1, 3'd4, 5'b01011};
      "Z": m = '{1'b1, 3'd4, 5'b01100};
      "0": m = '{1'b1, 3'd5, 5'b11111};
      "1": m = '{1'b1, 3'd5, 5'b01111};
      "2": m = '{1'b1, 3'd5, 5'b00111};
      "3": m = '{1'b1, 3'd5, 5'b00011};
      "4": m = '{1'b1, 3'd5, 5'b00001};
      "5": m = '{1'b1, 3'd5, 5'b00000};
      "6": m = '{1'b1, 3'd5, 5'b10000};
      "7": m = '{1'b1, 3'd5, 5'b11000};
      "8": m = '{1'b1, 3'd5, 5'b11100};
      "9": m = '{1'b1, 3'd5, 5'b11110};
      " ": m = '{1'b1, 3'd0, 5'b00000};
      default: m = '{1'b0, 3'd0, 5'b00000};
    endcase
    return m;
  endfunction

endpackage

// File: rtl/morse_rom.sv
// Combinational ASCII to Morse code-word lookup.
module morse_rom
  import morse_pkg::*;
(
  input  logic [7:0]  ch,
  output morse_code_t code
);

  assign code = ascii_to_morse(ch);

endmodule

// File: rtl/morse_keyer.sv
// Run-time Morse keyer: ASCII in over valid/ready, keyed level, unit tick and
// gated tone out. All outputs are registered from the next-state logic.
module morse_keyer
  import morse_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned UNIT_HZ = 4,
  parameter int unsigned TONE_HZ = 800
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic [7:0] iCHAR,
  input  logic       iVALID,
  output logic       oREADY,
  output logic       oKEY,
  output logic       oSOUND,
  output logic       oTICK,
  output logic       oERR,
  output logic       oBUSY
);

  localparam int unsigned TICK_DIV  = calc_tick_div(CLK_HZ, UNIT_HZ);
  localparam int unsigned TONE_HALF = calc_tone_half(CLK_HZ, TONE_HZ);
  localparam int unsigned CW        = $clog2(TICK_DIV);
  localparam int unsigned TW        = $clog2(TONE_HALF + 1);
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
  localparam logic [TW-1:0] TONE_LAST = TW'(TONE_HALF - 1);

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [1:0]      units, units_n;
  logic [2:0]      idx, idx_n;
  logic [TW-1:0]   tone_cnt;
  morse_code_t     code_q, rom_code;
  logic [2:0]      sel;
  logic [7:0]      pat_ext;
  logic [1:0]      last_unit;
  logic            unit_end;
  logic            accept;
  logic            timed_n;

  morse_rom u_rom (
    .ch   (iCHAR),
    .code (rom_code)
  );

  assign accept = (state == IDLE) && iVALID;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    units_n   = units;
    idx_n     = idx;
    sel       = code_q.len - 3'd1 - idx;
    pat_ext   = {3'b000, code_q.pat};
    last_unit = 2'd0;
    unit_end  = (cnt == TICK_LAST);

    case (state)
      MARK:    last_unit = pat_ext[sel] ? 2'd2 : 2'd0;
      CGAP:    last_unit = 2'd2;
      WGAP:    last_unit = 2'd3;
      default: last_unit = 2'd0;
    endcase

    case (state)
      IDLE: begin
        if (iVALID) state_n = LOAD;
      end
      LOAD: begin
        cnt_n   = '0;
        units_n = '0;
        idx_n   = '0;
        if (!code_q.valid)         state_n = IDLE;
        else if (code_q.len == '0) state_n = WGAP;
        else                       state_n = MARK;
      end
      default: begin
        if (!unit_end) begin
          cnt_n = cnt + 1'b1;
        end else begin
          cnt_n = '0;
          if (units != last_unit) begin
            units_n = units + 1'b1;
          end else begin
            units_n = '0;
            case (state)
              MARK:    state_n = (idx == code_q.len - 3'd1) ? CGAP : GAP;
              GAP: begin
                idx_n   = idx + 1'b1;
                state_n = MARK;
              end
              default: state_n = IDLE;
            endcase
          end
        end
      end
    endcase

    timed_n = (state_n == MARK) || (state_n == GAP) ||
              (state_n == CGAP) || (state_n == WGAP);
  end

  // The code word is captured at the accept edge so oERR can be a flop
  // that is high exactly during the LOAD cycle.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state  <= IDLE;
      cnt    <= '0;
      units  <= '0;
      idx    <= '0;
      code_q <= '0;
      oREADY <= 1'b1;
      oKEY   <= 1'b0;
      oTICK  <= 1'b0;
      oERR   <= 1'b0;
      oBUSY  <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      units  <= units_n;
      idx    <= idx_n;
      if (accept) code_q <= rom_code;
      oREADY <= (state_n == IDLE);
      oKEY   <= (state_n == MARK);
      oTICK  <= timed_n && (cnt_n == TICK_LAST);
      oERR   <= accept && !rom_code.valid;
      oBUSY  <= (state_n != IDLE);
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      oSOUND   <= 1'b0;
      tone_cnt <= '0;
    end else if (state_n == MARK) begin
      if (state != MARK) begin
        oSOUND   <= 1'b1;
        tone_cnt <= '0;
      end else if (tone_cnt == TONE_LAST) begin
        oSOUND   <= ~oSOUND;
        tone_cnt <= '0;
      end else begin
        tone_cnt <= tone_cnt + 1'b1;
      end
    end else begin
      oSOUND   <= 1'b0;
      tone_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_morse_keyer.sv
// Scoreboard bench for morse_keyer: expected key runs are queued per character
// and compared as the DUT emits them; tone, tick and error pulses are modelled per cycle.
module tb_morse_keyer;

  localparam int unsigned CLK_HZ  = 100;
  localparam int unsigned UNIT_HZ = 10;
  localparam int unsigned TONE_HZ = 25;
  localparam int UNIT      = 10;
  localparam int TONE_HALF = 2;

  logic       iCLK = 1'b0;
  logic       iRST = 1'b1;
  logic [7:0] iCHAR = '0;
  logic       iVALID = 1'b0;
  logic       oREADY, oKEY, oSOUND, oTICK, oERR, oBUSY;

  morse_keyer #(.CLK_HZ(CLK_HZ), .UNIT_HZ(UNIT_HZ), .TONE_HZ(TONE_HZ)) dut (
    .iCLK   (iCLK),
    .iRST   (iRST),
    .iCHAR  (iCHAR),
    .iVALID (iVALID),
    .oREADY (oREADY),
    .oKEY   (oKEY),
    .oSOUND (oSOUND),
    .oTICK  (oTICK),
    .oERR   (oERR),
    .oBUSY  (oBUSY)
  );

  always #5 iCLK = ~iCLK;

  typedef struct packed {
    logic        level;
    logic [15:0] len;
  } run_t;

  run_t run_q[$];
  bit   bad_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit morse_of(input byte c, output string s);
    byte u;
    u = c;
    if (u >= "a" && u <= "z") u = u - 8'sd32;
    morse_of = 1'b1;
    case (u)
      "A": s = ".-";
      "E": s = ".";
      "K": s = "-.-";
      "T": s = "-";
      "0": s = "-----";
      "5": s = ".....";
      "9": s = "----.";
      " ": s = "";
      default: begin s = ""; morse_of = 1'b0; end
    endcase
  endfunction

  task automatic expect_char(input byte c, output int dur);
    string s;
    bit    ok;
    int    m, g;
    ok = morse_of(c, s);
    bad_q.push_back(!ok);
    if (!ok) begin
      run_q.push_back('{1'b0, 16'd1});
      dur = 1;
    end else if (s.len() == 0) begin
      run_q.push_back('{1'b0, 16'(1 + 4 * UNIT)});
      dur = 1 + 4 * UNIT;
    end else begin
      run_q.push_back('{1'b0, 16'd1});
      dur = 1;
      for (int i = 0; i < s.len(); i++) begin
        m = (s[i] == "-") ? 3 * UNIT : UNIT;
        g = (i == s.len() - 1) ? 3 * UNIT : UNIT;
        run_q.push_back('{1'b1, 16'(m)});
        run_q.push_back('{1'b0, 16'(g)});
        dur += m + g;
      end
    end
  endtask

  task automatic put(input byte c, input bit hold, output int dur);
    int n;
    expect_char(c, dur);
    iCHAR  = c;
    iVALID = 1'b1;
    n = 0;
    while (!oREADY && n < 1000) begin
      @(negedge iCLK);
      n++;
    end
    if (!oREADY) check("accept_timeout", 32'(n), 32'd0);
    @(posedge iCLK);
    #1;
    check("accepted", 32'({oREADY, oBUSY}), 32'b01);
    if (!hold) iVALID = 1'b0;
  endtask

  task automatic finish_char(input int dur);
    int n;
    n = 0;
    forever begin
      @(negedge iCLK);
      if (oREADY || n >= 1000) break;
      n++;
    end
    check("ready_low", 32'(n), 32'(dur));
  endtask

  logic prev_key = 1'b0;
  logic run_level = 1'b0;
  int   key_cyc = 0, cyc = 0, run_len = 0;
  bit   in_char = 1'b0, cur_bad = 1'b0;

  task automatic close_run();
    run_t r;
    if (run_q.size() == 0) begin
      check("key_run_extra", 32'({run_level, 16'(run_len)}), 32'hFFFF_FFFF);
    end else begin
      r = run_q.pop_front();
      check("key_run", 32'({run_level, 16'(run_len)}), 32'(r));
    end
  endtask

  always @(negedge iCLK) begin
    if (iRST) begin
      in_char  = 1'b0;
      prev_key = 1'b0;
      key_cyc  = 0;
      cyc      = 0;
      cur_bad  = 1'b0;
    end else begin
      key_cyc  = (oKEY && prev_key) ? key_cyc + 1 : 0;
      prev_key = oKEY;
      if (oBUSY && !in_char) begin
        in_char   = 1'b1;
        cyc       = 0;
        run_level = oKEY;
        run_len   = 1;
        cur_bad   = (bad_q.size() != 0) ? bad_q.pop_front() : 1'b0;
      end else if (oBUSY) begin
        cyc++;
        if (oKEY == run_level) run_len++;
        else begin
          close_run();
          run_level = oKEY;
          run_len   = 1;
        end
      end else if (in_char) begin
        close_run();
        in_char = 1'b0;
      end
      check("sound", 32'(oSOUND), 32'(oKEY && ((key_cyc / TONE_HALF) % 2 == 0)));
      check("tick", 32'(oTICK), 32'(oBUSY && cyc != 0 && cyc % UNIT == 0));
      check("err", 32'(oERR), 32'(oBUSY && cyc == 0 && cur_bad));
    end
  end

  initial begin
    #200_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d, n;
    repeat (5) @(posedge iCLK);
    #1 iRST = 1'b0;
    @(negedge iCLK);
    check("rst_state", 32'({oREADY, oKEY, oSOUND, oTICK, oERR, oBUSY}), 32'b100000);
    repeat (50) @(negedge iCLK);
    check("idle_ready", 32'({oREADY, oBUSY}), 32'b10);

    put("E", 0, d); finish_char(d);

    put("A", 1, d); finish_char(d);
    put("T", 0, d); finish_char(d);

    put("e", 1, d); finish_char(d);
    put(" ", 1, d); finish_char(d);
    put("5", 0, d); finish_char(d);

    put("#", 0, d); finish_char(d);
    put("K", 0, d); finish_char(d);

    // abort in the middle of the first dash of '0', while the tone is high
    put("0", 0, d);
    n = 0;
    while (!oKEY && n < 100) begin
      @(negedge iCLK);
      n++;
    end
    repeat (16) @(negedge iCLK);
    check("pre_rst", 32'({oKEY, oSOUND}), 32'b11);
    #2 iRST = 1'b1;
    #1;
    check("rst_key", 32'(oKEY), 32'd0);
    check("rst_sound", 32'(oSOUND), 32'd0);
    repeat (3) @(posedge iCLK);
    #3;
    run_q.delete();
    bad_q.delete();
    iRST = 1'b0;
    @(negedge iCLK);
    check("post_rst", 32'({oREADY, oBUSY, oKEY}), 32'b100);

    put("E", 0, d); finish_char(d);
    put("9", 0, d); finish_char(d);

    repeat (5) @(negedge iCLK);
    check("runs_left", 32'(run_q.size()), 32'd0);
    check("bad_left", 32'(bad_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
